// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arbiter_pkg / imem_arbiter_if
//  Description : Bus command type and the handshake bundle between the icache
//                miss path, the instruction prefetcher, the instruction memory
//                and the fill consumer of imem_arbiter.
//                Modport slave  : the arbiter's view.
//                Modport master : the surrounding system's view.
//  Revision    : 1.0 - initial release
// ============================================================================

package imem_arbiter_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;
endpackage

interface imem_arbiter_if;
    import imem_arbiter_pkg::*;

    // Demand-fetch miss request
    logic         dmd_req_valid;
    logic [63:0]  dmd_req_addr;
    logic         dmd_req_ready;
    // Prefetch request
    logic         pf_req_valid;
    logic [63:0]  pf_req_addr;
    logic         pf_req_ready;
    // Instruction-memory bus
    bus_command_t proc2Imem_command;
    logic [63:0]  proc2Imem_addr;
    logic [3:0]   Imem2proc_response;
    logic [3:0]   Imem2proc_tag;
    logic [63:0]  Imem2proc_data;
    // Fill return and occupancy
    logic         fill_valid;
    logic [63:0]  fill_addr;
    logic [63:0]  fill_data;
    logic         fill_is_dmd;
    logic [3:0]   outstanding;

    modport slave (
        input  dmd_req_valid, dmd_req_addr,
        output dmd_req_ready,
        input  pf_req_valid, pf_req_addr,
        output pf_req_ready,
        output proc2Imem_command, proc2Imem_addr,
        input  Imem2proc_response, Imem2proc_tag, Imem2proc_data,
        output fill_valid, fill_addr, fill_data, fill_is_dmd, outstanding
    );

    modport master (
        output dmd_req_valid, dmd_req_addr,
        input  dmd_req_ready,
        output pf_req_valid, pf_req_addr,
        input  pf_req_ready,
        input  proc2Imem_command, proc2Imem_addr,
        output Imem2proc_response, Imem2proc_tag, Imem2proc_data,
        input  fill_valid, fill_addr, fill_data, fill_is_dmd, outstanding
    );
endinterface

`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arbiter
//  Description : Shares the instruction-memory bus between demand misses and
//                the prefetcher. Demand has priority; a prefetch that lost
//                STARVE_LIMIT consecutive times is forced through. Outstanding
//                transactions live in a miss table keyed by memory tag; each
//                return produces a registered one-cycle fill pulse.
//  Ports       : clock  - rising-edge clock
//                reset  - asynchronous, active-low
//                bus    - imem_arbiter_if.slave (requests, mem bus, fills,
//                         outstanding count)
//  Options     : IMEM_ARB_MERGE_EN - when defined, requests for a block that
//                is already outstanding are merged (demand) or dropped
//                (prefetch) instead of being issued again.
//  Revision    : 1.0 - initial release
// ============================================================================

module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int MSHR_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clock,
    input  logic          reset,
    imem_arbiter_if.slave bus
);

    localparam int         c_IDX_W        = $clog2(MSHR_DEPTH);
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    // Miss table
    logic [MSHR_DEPTH-1:0] r_valid;
    logic [MSHR_DEPTH-1:0] r_is_dmd;
    logic [3:0]            r_tag [MSHR_DEPTH];
    logic [63:3]           r_blk [MSHR_DEPTH];

    logic [3:0]            r_starve;
    logic                  r_fill_valid;
    logic [63:0]           r_fill_addr;
    logic [63:0]           r_fill_data;
    logic                  r_fill_is_dmd;

    logic [63:3]           w_dmd_blk;
    logic [63:3]           w_pf_blk;
    logic [63:3]           w_win_blk;
    logic                  w_full;
    logic [c_IDX_W-1:0]    w_free_idx;
    logic [MSHR_DEPTH-1:0] w_ret_hit;
    logic                  w_ret_any;
    logic [c_IDX_W-1:0]    w_ret_idx;
    logic [MSHR_DEPTH-1:0] w_dmd_match;
    logic [MSHR_DEPTH-1:0] w_pf_match;
    logic                  w_dmd_hit;
    logic                  w_pf_hit;
    logic                  w_pf_win;
    logic                  w_dmd_win;
    logic                  w_win_hit;
    logic                  w_issue;
    logic                  w_accept;
    logic                  w_dmd_merge;
    logic                  w_pf_drop;
    logic                  w_dmd_ready;
    logic                  w_pf_ready;
    logic [3:0]            w_count;
    logic                  w_unused_addr_bits;

    assign w_dmd_blk          = bus.dmd_req_addr[63:3];
    assign w_pf_blk           = bus.pf_req_addr[63:3];
    assign w_unused_addr_bits = ^{bus.dmd_req_addr[2:0], bus.pf_req_addr[2:0]};
    assign w_full             = &r_valid;

    // Lowest-index free entry and lowest-index entry matching the return tag
    always_comb begin
        w_free_idx = '0;
        w_ret_idx  = '0;
        w_ret_hit  = '0;
        w_count    = '0;
        for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = c_IDX_W'(i);
            end
            w_ret_hit[i] = r_valid[i] && (bus.Imem2proc_tag != 4'd0) &&
                           (r_tag[i] == bus.Imem2proc_tag);
            if (w_ret_hit[i]) begin
                w_ret_idx = c_IDX_W'(i);
            end
            w_count = w_count + {3'b000, r_valid[i]};
        end
    end
    assign w_ret_any = |w_ret_hit;

`ifdef IMEM_ARB_MERGE_EN
    always_comb begin
        w_dmd_match = '0;
        w_pf_match  = '0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            w_dmd_match[i] = r_valid[i] && (r_blk[i] == w_dmd_blk);
            w_pf_match[i]  = r_valid[i] && (r_blk[i] == w_pf_blk);
        end
    end
`else
    assign w_dmd_match = '0;
    assign w_pf_match  = '0;
`endif

    assign w_dmd_hit = bus.dmd_req_valid && (|w_dmd_match);
    assign w_pf_hit  = bus.pf_req_valid  && (|w_pf_match);

    // Arbitration: a starved prefetch overrides demand priority
    assign w_pf_win  = bus.pf_req_valid &&
                       ((r_starve == c_STARVE_LIMIT) || !bus.dmd_req_valid);
    assign w_dmd_win = bus.dmd_req_valid && !w_pf_win;
    assign w_win_hit = w_pf_win ? w_pf_hit : w_dmd_hit;
    assign w_win_blk = w_pf_win ? w_pf_blk : w_dmd_blk;

    // Only the winner touches the bus; either side may merge/drop as long as
    // it is not the one issuing. A full table blocks everything.
    assign w_issue     = reset && !w_full && (w_pf_win || w_dmd_win) && !w_win_hit;
    assign w_accept    = w_issue && (bus.Imem2proc_response != 4'd0);
    assign w_dmd_merge = reset && !w_full && w_dmd_hit;
    assign w_pf_drop   = reset && !w_full && w_pf_hit;
    assign w_dmd_ready = (w_dmd_win && w_accept) || w_dmd_merge;
    assign w_pf_ready  = (w_pf_win && w_accept) || w_pf_drop;

    assign bus.dmd_req_ready     = w_dmd_ready;
    assign bus.pf_req_ready      = w_pf_ready;
    assign bus.proc2Imem_command = w_issue ? BUS_LOAD : BUS_NONE;
    assign bus.proc2Imem_addr    = w_issue ? {w_win_blk, 3'b000} : 64'd0;
    assign bus.fill_valid        = r_fill_valid;
    assign bus.fill_addr         = r_fill_addr;
    assign bus.fill_data         = r_fill_data;
    assign bus.fill_is_dmd       = r_fill_is_dmd;
    assign bus.outstanding       = w_count;

    // Miss table: the free index is computed from the current valid bits, so
    // an entry freed by a return this cycle cannot be reallocated at this edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid  <= '0;
            r_is_dmd <= '0;
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                r_tag[i] <= '0;
                r_blk[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                if (w_ret_hit[i] && (w_ret_idx == c_IDX_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_dmd_merge && w_dmd_match[i]) begin
                    r_is_dmd[i] <= 1'b1;
                end
                if (w_accept && (w_free_idx == c_IDX_W'(i))) begin
                    r_valid[i]  <= 1'b1;
                    r_tag[i]    <= bus.Imem2proc_response;
                    r_blk[i]    <= w_win_blk;
                    r_is_dmd[i] <= w_dmd_win;
                end
            end
        end
    end

    // Starvation counter and fill register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve      <= '0;
            r_fill_valid  <= 1'b0;
            r_fill_addr   <= '0;
            r_fill_data   <= '0;
            r_fill_is_dmd <= 1'b0;
        end else begin
            if (!bus.pf_req_valid || w_pf_ready) begin
                r_starve <= '0;
            end else if (w_dmd_win && (r_starve != c_STARVE_LIMIT)) begin
                r_starve <= r_starve + 4'd1;
            end

            r_fill_valid <= w_ret_any;
            if (w_ret_any) begin
                r_fill_addr   <= {r_blk[w_ret_idx], 3'b000};
                r_fill_data   <= bus.Imem2proc_data;
                // A demand merging into the returning entry still counts
                r_fill_is_dmd <= r_is_dmd[w_ret_idx] |
                                 (w_dmd_merge && w_dmd_match[w_ret_idx]);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_arbiter
//  Description : Directed self-checking bench for imem_arbiter. Expected fills
//                are queued when a return tag is driven and compared when the
//                fill pulse appears. Build with IMEM_ARB_MERGE_EN to include
//                the merge scenario.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    imem_arbiter_if bus ();

    imem_arbiter #(
        .MSHR_DEPTH   (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic        is_dmd;
    } fill_t;

    fill_t sb [$];
    fill_t mon_exp;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        bus.dmd_req_valid      = 1'b0;
        bus.dmd_req_addr       = 64'd0;
        bus.pf_req_valid       = 1'b0;
        bus.pf_req_addr        = 64'd0;
        bus.Imem2proc_response = 4'd0;
        bus.Imem2proc_tag      = 4'd0;
        bus.Imem2proc_data     = 64'd0;
    endtask

    task automatic ret(input logic [3:0] tag, input logic [63:0] data,
                       input logic [63:0] addr, input logic is_dmd);
        fill_t f;
        bus.Imem2proc_tag  = tag;
        bus.Imem2proc_data = data;
        f.addr   = addr;
        f.data   = data;
        f.is_dmd = is_dmd;
        sb.push_back(f);
    endtask

    // Fill scoreboard
    always @(negedge clock) begin
        if (reset === 1'b1 && bus.fill_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("fill_unexpected", 64'(sb.size()), 64'd1);
            end else begin
                mon_exp = sb.pop_front();
                chk("fill_addr",   bus.fill_addr,         mon_exp.addr);
                chk("fill_data",   bus.fill_data,         mon_exp.data);
                chk("fill_is_dmd", 64'(bus.fill_is_dmd), 64'(mon_exp.is_dmd));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] st_tags [3];
        logic [3:0] dr_tags [4];
        logic [63:0] dr_addr [4];
        logic        dr_dmd [4];
        st_tags = '{4'd1, 4'd2, 4'd4};
        dr_tags = '{4'd4, 4'd6, 4'd8, 4'd9};
        dr_addr = '{64'h3010, 64'h4000, 64'h3018, 64'h3020};
        dr_dmd  = '{1'b1, 1'b0, 1'b1, 1'b1};

        // ---------------- reset state, with a request presented ----------
        set_idle();
        bus.dmd_req_valid      = 1'b1;
        bus.dmd_req_addr       = 64'h1004;
        bus.Imem2proc_response = 4'd3;
        #2;
        chk("rst_cmd",         64'(bus.proc2Imem_command), 64'(BUS_NONE));
        chk("rst_addr",        bus.proc2Imem_addr,         64'd0);
        chk("rst_dmd_ready",   64'(bus.dmd_req_ready),     64'd0);
        chk("rst_pf_ready",    64'(bus.pf_req_ready),      64'd0);
        chk("rst_outstanding", 64'(bus.outstanding),       64'd0);
        chk("rst_fill_valid",  64'(bus.fill_valid),        64'd0);
        chk("rst_fill_addr",   bus.fill_addr,              64'd0);
        chk("rst_fill_data",   bus.fill_data,              64'd0);
        chk("rst_fill_is_dmd", 64'(bus.fill_is_dmd),       64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        set_idle();
        reset = 1'b1;
        step();

        // ---------------- basic demand miss and fill ---------------------
        bus.dmd_req_valid      = 1'b1;
        bus.dmd_req_addr       = 64'h1004;
        bus.Imem2proc_response = 4'd3;
        #1;
        chk("t1_cmd",       64'(bus.proc2Imem_command), 64'(BUS_LOAD));
        chk("t1_addr",      bus.proc2Imem_addr,         64'h1000);
        chk("t1_dmd_ready", 64'(bus.dmd_req_ready),     64'd1);
        chk("t1_pf_ready",  64'(bus.pf_req_ready),      64'd0);
        step();
        set_idle();
        #1;
        chk("t1_outstanding", 64'(bus.outstanding), 64'd1);
        step();
        ret(4'd3, 64'hDEAD, 64'h1000, 1'b1);
        step();
        set_idle();
        #1;
        chk("t1_fill_valid",   64'(bus.fill_valid),  64'd1);
        chk("t1_outstanding0", 64'(bus.outstanding), 64'd0);
        step();
        chk("t1_fill_pulse", 64'(bus.fill_valid), 64'd0);

        // ---------------- starvation: 3 demand wins, then prefetch -------
        bus.dmd_req_valid = 1'b1;
        bus.pf_req_valid  = 1'b1;
        bus.pf_req_addr   = 64'h4000;
        for (int k = 0; k < 3; k++) begin
            bus.dmd_req_addr       = 64'h3000 + 64'(8 * k);
            bus.Imem2proc_response = st_tags[k];
            #1;
            chk("st_dmd_addr",  bus.proc2Imem_addr,     64'h3000 + 64'(8 * k));
            chk("st_dmd_ready", 64'(bus.dmd_req_ready), 64'd1);
            chk("st_pf_ready",  64'(bus.pf_req_ready),  64'd0);
            step();
        end
        bus.dmd_req_addr       = 64'h3018;
        bus.Imem2proc_response = 4'd6;
        ret(4'd1, 64'h1111, 64'h3000, 1'b1);
        #1;
        chk("st_forced_addr",  bus.proc2Imem_addr,     64'h4000);
        chk("st_forced_pf",    64'(bus.pf_req_ready),  64'd1);
        chk("st_forced_dmd",   64'(bus.dmd_req_ready), 64'd0);
        step();
        // counter cleared: demand wins again despite a valid prefetch
        bus.Imem2proc_tag      = 4'd0;
        bus.pf_req_addr        = 64'h4040;
        bus.Imem2proc_response = 4'd8;
        #1;
        chk("st_clr_addr",  bus.proc2Imem_addr,     64'h3018);
        chk("st_clr_dmd",   64'(bus.dmd_req_ready), 64'd1);
        chk("st_clr_pf",    64'(bus.pf_req_ready),  64'd0);
        chk("st_fill_seen", 64'(bus.fill_valid),    64'd1);
        step();

        // ---------------- full table, return frees next cycle ------------
        bus.pf_req_valid       = 1'b0;
        bus.dmd_req_addr       = 64'h3020;
        bus.Imem2proc_response = 4'd9;
        ret(4'd2, 64'h2222, 64'h3008, 1'b1);
        #1;
        chk("full_cmd",         64'(bus.proc2Imem_command), 64'(BUS_NONE));
        chk("full_dmd_ready",   64'(bus.dmd_req_ready),     64'd0);
        chk("full_outstanding", 64'(bus.outstanding),       64'd4);
        step();
        bus.Imem2proc_tag = 4'd0;
        #1;
        chk("free_fill",        64'(bus.fill_valid),        64'd1);
        chk("free_outstanding", 64'(bus.outstanding),       64'd3);
        chk("free_cmd",         64'(bus.proc2Imem_command), 64'(BUS_LOAD));
        chk("free_addr",        bus.proc2Imem_addr,         64'h3020);
        chk("free_dmd_ready",   64'(bus.dmd_req_ready),     64'd1);
        step();
        set_idle();
        #1;
        chk("refull_outstanding", 64'(bus.outstanding), 64'd4);

        // ---------------- drain ------------------------------------------
        for (int k = 0; k < 4; k++) begin
            ret(dr_tags[k], 64'hA000 + 64'(k), dr_addr[k], dr_dmd[k]);
            step();
        end
        set_idle();
        step();
        chk("drain_outstanding", 64'(bus.outstanding), 64'd0);

        // ---------------- rejected response then accepted ----------------
        bus.dmd_req_valid = 1'b1;
        bus.dmd_req_addr  = 64'h5000;
        #1;
        chk("r0_cmd",   64'(bus.proc2Imem_command), 64'(BUS_LOAD));
        chk("r0_ready", 64'(bus.dmd_req_ready),     64'd0);
        step();
        chk("r0_outstanding", 64'(bus.outstanding), 64'd0);
        bus.Imem2proc_response = 4'd7;
        #1;
        chk("r7_ready", 64'(bus.dmd_req_ready), 64'd1);
        step();
        set_idle();
        #1;
        chk("r7_outstanding", 64'(bus.outstanding), 64'd1);

`ifdef IMEM_ARB_MERGE_EN
        // ---------------- demand merges into an outstanding prefetch -----
        bus.pf_req_valid       = 1'b1;
        bus.pf_req_addr        = 64'h2000;
        bus.Imem2proc_response = 4'd5;
        #1;
        chk("mg_pf_ready", 64'(bus.pf_req_ready),      64'd1);
        chk("mg_pf_cmd",   64'(bus.proc2Imem_command), 64'(BUS_LOAD));
        step();
        set_idle();
        bus.dmd_req_valid      = 1'b1;
        bus.dmd_req_addr       = 64'h2000;
        bus.Imem2proc_response = 4'd11;
        #1;
        chk("mg_cmd",       64'(bus.proc2Imem_command), 64'(BUS_NONE));
        chk("mg_dmd_ready", 64'(bus.dmd_req_ready),     64'd1);
        step();
        set_idle();
        #1;
        chk("mg_outstanding", 64'(bus.outstanding), 64'd2);
        ret(4'd5, 64'h5555, 64'h2000, 1'b1);
        step();
        set_idle();
        #1;
        chk("mg_fill_valid",  64'(bus.fill_valid),  64'd1);
        chk("mg_outstanding1", 64'(bus.outstanding), 64'd1);
`endif

        // ---------------- asynchronous reset mid-operation ---------------
        bus.dmd_req_valid      = 1'b1;
        bus.dmd_req_addr       = 64'h6000;
        bus.Imem2proc_response = 4'd10;
        step();
        set_idle();
        #1;
        chk("rs_outstanding_pre", 64'(bus.outstanding), 64'd2);
        bus.Imem2proc_tag  = 4'd7;
        bus.Imem2proc_data = 64'h7777;
        step();
        chk("rs_fill_pre",      64'(bus.fill_valid), 64'd1);
        chk("rs_fill_addr_pre", bus.fill_addr,       64'h5000);
        set_idle();
        bus.dmd_req_valid      = 1'b1;
        bus.dmd_req_addr       = 64'h7000;
        bus.Imem2proc_response = 4'd12;
        reset = 1'b0;
        #1;
        chk("rs_fill_valid",  64'(bus.fill_valid),        64'd0);
        chk("rs_fill_addr",   bus.fill_addr,              64'd0);
        chk("rs_fill_data",   bus.fill_data,              64'd0);
        chk("rs_outstanding", 64'(bus.outstanding),       64'd0);
        chk("rs_cmd",         64'(bus.proc2Imem_command), 64'(BUS_NONE));
        chk("rs_dmd_ready",   64'(bus.dmd_req_ready),     64'd0);
        @(negedge clock);
        set_idle();
        reset = 1'b1;
        bus.Imem2proc_tag  = 4'd10;
        bus.Imem2proc_data = 64'hBAD0;
        step();
        set_idle();
        chk("rs_stale_fill",        64'(bus.fill_valid),  64'd0);
        chk("rs_stale_outstanding", 64'(bus.outstanding), 64'd0);
        step();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
